regfile_nwords: RTL and testbench
=================================

// Module: regfile_nwords
// PURPOSE
//  Parametrised register bank; successor to the single 32-bit gated register.
//  Holds NUM_REGS words of WIDTH bits. Has one byte-enabled write port and two
//  independent gated read ports. Includes a hardware sweep-clear engine.
//  Sits between decode and execute as the CPU general-purpose register file.
// PARAMETERS
//  WIDTH      32  word width in bits; must be a multiple of 8 (elaboration $error otherwise)
//  NUM_REGS   16  number of words; >= 2; need not be a power of two
//  READ_REG   0   0 = combinational reads; 1 = registered reads (1-cycle latency, write-first bypass)
//  ZERO_REG0  0   1 = word 0 is hardwired to zero: reads return 0, writes are dropped
//  AW         $clog2(NUM_REGS)  address width (derived; do not override)
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        asynchronous active-low reset
//  we       in   1        write request
//  waddr    in   AW       write address
//  wdata    in   WIDTH    write data
//  wbe      in   WIDTH/8  byte enables; bit i selects wdata[8i+7:8i]
//  re_a     in   1        read enable, port A
//  raddr_a  in   AW       read address, port A
//  rdata_a  out  WIDTH    read data A; 0 when not enabled
//  re_b     in   1        read enable, port B
//  raddr_b  in   AW       read address, port B
//  rdata_b  out  WIDTH    read data B; 0 when not enabled
//  clr_req  in   1        pulse: start sweep-clear of all words
//  busy     out  1        high while the sweep-clear is in progress
// BEHAVIOUR
//  Reset (rst_n low, async): all words 0; FSM -> IDLE; busy 0; registered rdata_* 0.
//  Write: at posedge, word[waddr] byte i <= wdata byte i only when all of these hold:
//    we=1, wbe[i]=1, busy=0, waddr<NUM_REGS, and !(ZERO_REG0 && waddr==0).
//    we with wbe=0 is a no-op.
//  Read, READ_REG=0: rdata_x = (re_x && raddr_x<NUM_REGS) ? word[raddr_x] : 0, combinational.
//    A same-cycle write is not visible; the new value appears the next cycle.
//  Read, READ_REG=1: rdata_x is registered at posedge with the same gating rule.
//    If the same edge writes raddr_x, rdata_x captures the byte-merged new word (write-first).
//    With re_x=0 the register loads 0; rdata_x does not hold its old value.
//  Out-of-range address (>= NUM_REGS): reads return 0; writes are ignored.
//  Ports A and B are fully independent and may use the same address.
//  FSM, states IDLE and CLEAR, with pointer ptr (AW bits):
//    IDLE : clr_req=1 -> CLEAR, ptr<=0, busy<=1 (busy registered; rises the cycle after clr_req).
//    CLEAR: each cycle word[ptr]<=0 and ptr<=ptr+1.
//           When ptr==NUM_REGS-1, clear that word, then -> IDLE with busy<=0.
//    busy is therefore high for exactly NUM_REGS cycles.
//  During CLEAR:
//    - we is dropped silently; there is no stall and no queueing.
//    - reads are served normally and may show partially cleared contents.
//    - clr_req is ignored.
//  A clr_req on the same edge as a write in IDLE: the write lands, then the sweep erases it.
//  rst_n asserted mid-sweep: immediate return to IDLE, all state zero.
// STRUCTURE
//  Package regfile_pkg:
//    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;
//    function byte_merge(old, wdata, wbe), shared by the storage and bypass paths.
//  Sub-module regfile_word: one WIDTH-bit word with async active-low reset,
//    byte-enable write and a synchronous clear input. Instantiated NUM_REGS times via generate.
//  Top level contains the address decode, the two read muxes with gating, the optional
//    read registers and bypass, and the clear FSM.
// TESTING (run WIDTH=32, NUM_REGS=16 with READ_REG 0 and 1; plus a NUM_REGS=12 build)
//  1 Reset: hold rst_n=0, then release; re_a=1 at each addr 0..15 -> rdata_a=0, busy=0.
//  2 Byte write: we, waddr=3, wdata=32'hAABBCCDD, wbe=4'b0101 on a zeroed word
//    -> word3=32'h00BB00DD; rdata_b via addr 3 matches; re_b=0 -> rdata_b=0.
//  3 Bypass (READ_REG=1): write 32'h12345678 to addr 5 and read addr 5 on the same edge
//    -> rdata_a=32'h12345678 one cycle later.
//    With READ_REG=0 the same-cycle read returns the old value.
//  4 ZERO_REG0=1 / range: write 32'hFFFFFFFF to addr 0 -> read 0.
//    NUM_REGS=12: write to addr 13 -> no word changes; read addr 13 -> 0.
//  5 Sweep: fill all words with 32'hDEADBEEF, pulse clr_req -> busy high for 16 cycles;
//    a we to addr 7 at cycle 4 is dropped; all words 0 afterwards.
//  6 Reset mid-sweep: assert rst_n=0 at sweep cycle 6
//    -> busy=0 immediately; all words 0; a new clr_req works normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and byte-merge helper for the register bank
package regfile_pkg;

    typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_e;

    // Widest word the merge helper handles; callers extend and truncate around it.
    localparam int RF_MAX_W = 256;

    function automatic logic [RF_MAX_W-1:0] byte_merge(
        input logic [RF_MAX_W-1:0]   old,
        input logic [RF_MAX_W-1:0]   wdata,
        input logic [RF_MAX_W/8-1:0] wbe
    );
        logic [RF_MAX_W-1:0] r;
        r = old;
        for (int i = 0; i < RF_MAX_W / 8; i++) begin
            if (wbe[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// rtl/regfile_word.sv - one storage word with byte-enable write and synchronous clear
module regfile_word
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               clr,
    output logic [WIDTH-1:0]   q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= WIDTH'(byte_merge(RF_MAX_W'(q), RF_MAX_W'(wdata), (RF_MAX_W/8)'(be)));
        end
    end

endmodule

// File: rtl/regfile_nwords.sv
// rtl/regfile_nwords.sv - NUM_REGS x WIDTH register bank, two gated read ports, sweep-clear
module regfile_nwords
    import regfile_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 16,
    parameter int READ_REG  = 0,
    parameter int ZERO_REG0 = 0,
    parameter int AW        = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic               re_a,
    input  logic [AW-1:0]      raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic               re_b,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_b,
    input  logic               clr_req,
    output logic               busy
);

    localparam int DEPTH = 1 << AW;

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("regfile_nwords: WIDTH must be a multiple of 8");
    end
    if (NUM_REGS < 2) begin : g_bad_depth
        $error("regfile_nwords: NUM_REGS must be at least 2");
    end

    rf_state_e      state;
    logic [AW-1:0]  ptr;
    logic           wr_ok;
    logic           gate_a;
    logic           gate_b;
    logic [WIDTH-1:0] rd_a_comb;
    logic [WIDTH-1:0] rd_b_comb;
    logic [WIDTH-1:0] words [DEPTH];

    assign wr_ok  = we && !busy && (32'(waddr) < NUM_REGS) && !(ZERO_REG0 != 0 && waddr == '0);
    assign gate_a = re_a && (32'(raddr_a) < NUM_REGS) && !(ZERO_REG0 != 0 && raddr_a == '0);
    assign gate_b = re_b && (32'(raddr_b) < NUM_REGS) && !(ZERO_REG0 != 0 && raddr_b == '0);

    // Addresses past NUM_REGS map to constant-zero slots so the muxes stay power-of-two.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (i < NUM_REGS) begin : g_real
            regfile_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (wr_ok && waddr == AW'(i)),
                .be    (wbe),
                .wdata (wdata),
                .clr   (state == RF_CLEAR && ptr == AW'(i)),
                .q     (words[i])
            );
        end else begin : g_pad
            assign words[i] = '0;
        end
    end

    assign rd_a_comb = gate_a ? words[raddr_a] : '0;
    assign rd_b_comb = gate_b ? words[raddr_b] : '0;

    if (READ_REG != 0) begin : g_rreg
        logic [WIDTH-1:0] wmerged;
        logic [WIDTH-1:0] rd_a_next;
        logic [WIDTH-1:0] rd_b_next;

        assign wmerged = WIDTH'(byte_merge(RF_MAX_W'(words[waddr]), RF_MAX_W'(wdata),
                                           (RF_MAX_W/8)'(wbe)));

        // Write-first: a same-edge write to the read address is forwarded.
        always_comb begin
            rd_a_next = rd_a_comb;
            rd_b_next = rd_b_comb;
            if (gate_a && wr_ok && waddr == raddr_a) rd_a_next = wmerged;
            if (gate_b && wr_ok && waddr == raddr_b) rd_b_next = wmerged;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_a <= '0;
                rdata_b <= '0;
            end else begin
                rdata_a <= rd_a_next;
                rdata_b <= rd_b_next;
            end
        end
    end else begin : g_rcomb
        assign rdata_a = rd_a_comb;
        assign rdata_b = rd_b_comb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state <= RF_CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    if (ptr == AW'(NUM_REGS - 1)) begin
                        state <= RF_IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_nwords.sv
// tb/tb_regfile_nwords.sv - three configurations driven in lockstep against an array model
module tb_regfile_nwords;

    localparam int NDUT = 3;
    localparam int NR [NDUT] = '{16, 16, 12};
    localparam int RR [NDUT] = '{0, 1, 0};
    localparam int ZR [NDUT] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        re_a = 1'b0;
    logic [3:0]  raddr_a = '0;
    logic        re_b = 1'b0;
    logic [3:0]  raddr_b = '0;
    logic        clr_req = 1'b0;

    logic [31:0] ra [NDUT];
    logic [31:0] rb [NDUT];
    logic        bz [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem   [NDUT][16];
    logic [31:0] reg_a [NDUT];
    logic [31:0] reg_b [NDUT];
    int          sweep [NDUT];

    always #5 clk = ~clk;

    regfile_nwords #(.WIDTH(32), .NUM_REGS(16), .READ_REG(0), .ZERO_REG0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(ra[0]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rb[0]),
        .clr_req(clr_req), .busy(bz[0]));

    regfile_nwords #(.WIDTH(32), .NUM_REGS(16), .READ_REG(1), .ZERO_REG0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(ra[1]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rb[1]),
        .clr_req(clr_req), .busy(bz[1]));

    regfile_nwords #(.WIDTH(32), .NUM_REGS(12), .READ_REG(0), .ZERO_REG0(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(ra[2]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rb[2]),
        .clr_req(clr_req), .busy(bz[2]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic re, input logic [3:0] a);
        if (re && int'(a) < NR[k] && !(ZR[k] != 0 && a == 0)) return mem[k][a];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
            reg_a[k] = '0;
            reg_b[k] = '0;
            sweep[k] = -1;
        end
    endtask

    // Called in the low phase with inputs already set; ends at the next falling edge.
    task automatic cycle();
        logic [31:0] ea, eb;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            ea = (RR[k] != 0) ? reg_a[k] : model_read(k, re_a, raddr_a);
            eb = (RR[k] != 0) ? reg_b[k] : model_read(k, re_b, raddr_b);
            check_eq($sformatf("rdata_a[%0d]", k), ra[k], ea);
            check_eq($sformatf("rdata_b[%0d]", k), rb[k], eb);
            check_eq($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(sweep[k] >= 0));
        end
        for (int k = 0; k < NDUT; k++) begin
            if (we && sweep[k] < 0 && int'(waddr) < NR[k] && !(ZR[k] != 0 && waddr == 0)) begin
                for (int i = 0; i < 4; i++)
                    if (wbe[i]) mem[k][waddr][8*i +: 8] = wdata[8*i +: 8];
            end
            reg_a[k] = model_read(k, re_a, raddr_a);
            reg_b[k] = model_read(k, re_b, raddr_b);
            if (sweep[k] >= 0) begin
                mem[k][sweep[k]] = '0;
                sweep[k]++;
                if (sweep[k] == NR[k]) sweep[k] = -1;
            end else if (clr_req) begin
                sweep[k] = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scan_all();
        re_a = 1'b1;
        re_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            raddr_b = 4'(15 - i);
            cycle();
        end
        re_a = 1'b0;
        re_b = 1'b0;
        cycle();
    endtask

    task automatic fill(input logic [31:0] v);
        we = 1'b1;
        wbe = 4'hF;
        wdata = v;
        for (int i = 0; i < 16; i++) begin
            waddr = 4'(i);
            cycle();
        end
        we = 1'b0;
    endtask

    int cnt0, cnt2;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset contents
        re_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            cycle();
        end
        re_a = 1'b0;

        // Byte-enable write
        we = 1'b1; waddr = 4'd3; wdata = 32'hAABBCCDD; wbe = 4'b0101;
        cycle();
        we = 1'b0; re_b = 1'b1; raddr_b = 4'd3;
        cycle();
        check_eq("byte_wr_comb", rb[0], 32'h00BB00DD);
        check_eq("byte_wr_reg", rb[1], 32'h00BB00DD);
        re_b = 1'b0;
        cycle();
        check_eq("re_b_off_comb", rb[0], 32'h0);
        check_eq("re_b_off_reg", rb[1], 32'h0);

        // Same-edge write and read
        we = 1'b1; waddr = 4'd5; wdata = 32'h12345678; wbe = 4'hF;
        re_a = 1'b1; raddr_a = 4'd5;
        #1;
        check_eq("same_cycle_old", ra[0], 32'h0);
        cycle();
        check_eq("bypass_reg", ra[1], 32'h12345678);
        check_eq("after_write_comb", ra[0], 32'h12345678);
        we = 1'b0;

        // Zero register and out-of-range address
        we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
        cycle();
        we = 1'b0; raddr_a = 4'd0;
        cycle();
        check_eq("zero_reg0", ra[1], 32'h0);
        we = 1'b1; waddr = 4'd13; wdata = 32'hDEAD1313;
        cycle();
        we = 1'b0; raddr_a = 4'd13;
        cycle();
        check_eq("oor_read", ra[2], 32'h0);
        re_a = 1'b0;
        scan_all();

        // Full sweep with a dropped write inside it
        fill(32'hDEADBEEF);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cnt0 = 0; cnt2 = 0;
        for (int c = 0; c < 20; c++) begin
            if (bz[0]) cnt0++;
            if (bz[2]) cnt2++;
            we = (c == 4);
            waddr = 4'd7; wdata = 32'h77777777; wbe = 4'hF;
            clr_req = (c == 6);
            cycle();
        end
        we = 1'b0; clr_req = 1'b0;
        check_eq("busy_len16", 32'(cnt0), 32'd16);
        check_eq("busy_len12", 32'(cnt2), 32'd12);
        scan_all();

        // Reset during a sweep
        fill(32'hDEADBEEF);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int c = 0; c < 6; c++) cycle();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("rst_busy[%0d]", k), 32'(bz[k]), 32'h0);
            check_eq($sformatf("rst_ra[%0d]", k), ra[k], 32'h0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scan_all();
        fill(32'h5A5A5A5A);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cnt0 = 0;
        for (int c = 0; c < 20; c++) begin
            if (bz[0]) cnt0++;
            cycle();
        end
        check_eq("busy_after_rst", 32'(cnt0), 32'd16);
        scan_all();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = 4'($urandom_range(0, 15));
            wdata   = $urandom;
            wbe     = 4'($urandom_range(0, 15));
            re_a    = 1'($urandom_range(0, 3) != 0);
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            re_b    = 1'($urandom_range(0, 3) != 0);
            raddr_b = 4'($urandom_range(0, 15));
            clr_req = ($urandom_range(0, 59) == 0);
            cycle();
        end
        we = 1'b0; clr_req = 1'b0;
        for (int c = 0; c < 20; c++) cycle();
        scan_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
